// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: request/response handshake plus memory_block strobe bus
// seen by mem_access_ctrl (slave side) and its datapath/memory environment (master side).
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_byte;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_error;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              memRead;
    logic              memWrite;
    logic              byteOperations;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
        input  resp_ready, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_address, mem_write_data, memRead, memWrite, byteOperations
    );

    modport master (
        output req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
        output resp_ready, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_address, mem_write_data, memRead, memWrite, byteOperations
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: one-request-at-a-time load/store sequencer issuing one-shot strobes to memory_block.
// Define MISALIGN_TRAP_EN to trap misaligned word accesses instead of forcing word alignment.
module mem_access_ctrl #(
    parameter int ADDR_W        = 18,
    parameter int DATA_W        = 32,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 1
) (
    input logic              clk,
    input logic              reset,
    mem_access_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, CAPTURE, RESP} state_t;

    localparam int MAXC = SETUP_CYCLES > STROBE_CYCLES ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int CW   = MAXC > 1 ? $clog2(MAXC) : 1;

    state_t            state, nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              accept, trap, strobe_nxt;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic              byte_q, sgn_q, wr_q, err_q, rd_strb_q, wr_strb_q;

    assign accept = state == IDLE && bus.req_valid;

`ifdef MISALIGN_TRAP_EN
    assign trap   = ~bus.req_byte && |bus.req_addr[1:0];
    assign addr_d = bus.req_addr;
`else
    assign trap   = 1'b0;
    assign addr_d = bus.req_byte ? bus.req_addr : {bus.req_addr[ADDR_W-1:2], 2'b00};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
        end
    end

    // strobe_nxt marks cycles in which the registered strobe must be high
    always_comb begin
        nxt        = state;
        cnt_nxt    = '0;
        strobe_nxt = 1'b0;
        case (state)
            IDLE:    nxt = accept ? (trap ? RESP : SETUP) : IDLE;
            SETUP:
                if (cnt == CW'(SETUP_CYCLES - 1)) begin
                    nxt        = STROBE;
                    strobe_nxt = 1'b1;
                end else cnt_nxt = cnt + CW'(1);
            STROBE:
                if (cnt == CW'(STROBE_CYCLES - 1)) nxt = wr_q ? RESP : CAPTURE;
                else begin
                    cnt_nxt    = cnt + CW'(1);
                    strobe_nxt = 1'b1;
                end
            CAPTURE: nxt = RESP;
            RESP:    nxt = bus.resp_ready ? IDLE : RESP;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            byte_q    <= 1'b0;
            sgn_q     <= 1'b0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            rd_strb_q <= 1'b0;
            wr_strb_q <= 1'b0;
        end else begin
            rd_strb_q <= strobe_nxt & ~wr_q;
            wr_strb_q <= strobe_nxt & wr_q;
            if (accept) begin
                addr_q  <= addr_d;
                wdata_q <= bus.req_wdata;
                byte_q  <= bus.req_byte;
                sgn_q   <= bus.req_signed;
                wr_q    <= bus.req_write;
                err_q   <= trap;
                rdata_q <= '0;
            end
            if (state == CAPTURE)
                rdata_q <= byte_q ? {{(DATA_W-8){sgn_q & bus.mem_read_data[7]}}, bus.mem_read_data[7:0]}
                                  : bus.mem_read_data;
        end
    end

    assign bus.req_ready      = state == IDLE;
    assign bus.resp_valid     = state == RESP;
    assign bus.resp_rdata     = rdata_q;
    assign bus.resp_error     = err_q;
    assign bus.mem_address    = addr_q;
    assign bus.mem_write_data = wdata_q;
    assign bus.byteOperations = byte_q;
    assign bus.memRead        = rd_strb_q;
    assign bus.memWrite       = wr_strb_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: vector table, corner sequences and random traffic against a byte-array reference.
module tb_mem_access_ctrl;
    localparam int SC = 1;
    localparam int TC = 1;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_access_ctrl_if bus ();
    mem_access_ctrl_if bus2 ();

    mem_access_ctrl #(.ADDR_W(18), .DATA_W(32), .SETUP_CYCLES(SC), .STROBE_CYCLES(TC))
        dut (.clk(clk), .reset(reset), .bus(bus.slave));
    mem_access_ctrl #(.ADDR_W(18), .DATA_W(32), .SETUP_CYCLES(2), .STROBE_CYCLES(3))
        dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

    // edge-triggered memory_block stand-in
    logic [7:0] mm [0:1023] = '{default: 8'h00};
    always @(posedge bus.memWrite) begin
        if (bus.byteOperations) mm[bus.mem_address[9:0]] = bus.mem_write_data[7:0];
        else for (int i = 0; i < 4; i++) mm[int'(bus.mem_address[9:0]) + i] = bus.mem_write_data[8*i +: 8];
    end
    always @(posedge bus.memRead) begin
        int ma;
        ma = int'(bus.mem_address[9:0]);
        bus.mem_read_data = bus.byteOperations ? {24'hA55AC3, mm[ma]} : {mm[ma+3], mm[ma+2], mm[ma+1], mm[ma]};
    end
    always @(posedge bus2.memRead) bus2.mem_read_data = 32'hCAFE0123;

    // reference byte memory, updated from the request stream alone
    logic [7:0] rm [0:1023] = '{default: 8'h00};

    function automatic logic is_trap(input logic b, input logic [17:0] a);
        return TRAP && !b && a[1:0] != 2'b00;
    endfunction

    function automatic logic [32:0] ref_resp(input logic w, b, s, input logic [17:0] a);
        int ea;
        if (is_trap(b, a)) return {1'b1, 32'h0};
        if (w) return 33'h0;
        if (b) return {1'b0, (s && rm[a] >= 8'd128) ? 32'(rm[a]) + 32'hFFFFFF00 : 32'(rm[a])};
        ea = int'(a) / 4 * 4;
        return {1'b0, 32'(rm[ea]) + (32'(rm[ea+1]) << 8) + (32'(rm[ea+2]) << 16) + (32'(rm[ea+3]) << 24)};
    endfunction

    task automatic ref_store(input logic w, b, input logic [17:0] a, input logic [31:0] d);
        int ea;
        if (!w || is_trap(b, a)) return;
        if (b) rm[a] = d[7:0];
        else begin
            ea = int'(a) / 4 * 4;
            for (int i = 0; i < 4; i++) rm[ea+i] = d[8*i +: 8];
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic run_check(input string tag, input logic w, b, s, input logic [17:0] a,
                             input logic [31:0] d, input int hold, input logic [31:0] exp_rd, input logic exp_er);
        logic tr;
        int k, nrd, nwr, both, rdy, moved;
        logic [17:0] ma;
        logic [31:0] mwd;
        logic bop;
        tr = is_trap(b, a);
        @(negedge clk);
        bus.req_write = w; bus.req_byte = b; bus.req_signed = s; bus.req_addr = a; bus.req_wdata = d;
        bus.req_valid = 1'b1; bus.resp_ready = 1'($urandom % 2);
        k = 0;
        while (!bus.req_ready && k < 20) begin @(negedge clk); k++; end
        chk({tag, "_ready"}, bus.req_ready, 1);
        @(negedge clk);
        bus.req_valid = 1'($urandom % 2); bus.req_addr = 18'($urandom); bus.req_wdata = $urandom;
        bus.req_write = 1'($urandom % 2); bus.req_byte = 1'($urandom % 2);
        ma = bus.mem_address; mwd = bus.mem_write_data; bop = bus.byteOperations;
        k = 1; nrd = 0; nwr = 0; both = 0; rdy = 0; moved = 0;
        while (!bus.resp_valid && k < 40) begin
            nrd += int'(bus.memRead); nwr += int'(bus.memWrite);
            both += int'(bus.memRead & bus.memWrite); rdy += int'(bus.req_ready);
            moved += int'(bus.mem_address !== ma);
            @(negedge clk);
            bus.req_valid = 1'($urandom % 2); bus.resp_ready = 1'($urandom % 2);
            k++;
        end
        chk({tag, "_lat"}, k, tr ? 1 : SC + TC + (w ? 0 : 1) + 1);
        chk({tag, "_rdata"}, bus.resp_rdata, exp_rd);
        chk({tag, "_err"}, bus.resp_error, exp_er);
        chk({tag, "_nread"}, nrd, (!tr && !w) ? 1 : 0);
        chk({tag, "_nwrite"}, nwr, (!tr && w) ? 1 : 0);
        chk({tag, "_both"}, both, 0);
        chk({tag, "_busy_ready"}, rdy, 0);
        chk({tag, "_addr_moved"}, moved, 0);
        chk({tag, "_mem_addr"}, ma, (TRAP || b) ? a : {a[17:2], 2'b00});
        chk({tag, "_mem_wdata"}, mwd, d);
        chk({tag, "_byteop"}, bop, b);
        bus.resp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bus.req_valid = 1'($urandom % 2);
            chk({tag, "_hold_valid"}, bus.resp_valid, 1);
            chk({tag, "_hold_rdata"}, bus.resp_rdata, exp_rd);
            chk({tag, "_hold_ready"}, bus.req_ready, 0);
            chk({tag, "_hold_strobe"}, bus.memRead | bus.memWrite, 0);
        end
        bus.req_valid = 1'b0; bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk({tag, "_done"}, {bus.resp_valid, bus.req_ready}, 2'b01);
    endtask

    typedef struct {
        logic        w, b, s;
        logic [17:0] a;
        logic [31:0] d;
        int          hold;
        logic [31:0] exp_rd;
        logic        exp_er;
    } vec_t;

    vec_t tv [12];

    initial begin
        int k, first, n, moved;
        logic [17:0] ma2;
        logic [32:0] r;
        logic w, b, s;
        logic [17:0] a;
        logic [31:0] d;

        tv[0]  = '{1, 0, 0, 18'h010, 32'hDEADBEEF, 0, 32'h0, 0};
        tv[1]  = '{0, 0, 0, 18'h010, 32'h0, 5, 32'hDEADBEEF, 0};
        tv[2]  = '{1, 1, 0, 18'h021, 32'h12345680, 0, 32'h0, 0};
        tv[3]  = '{0, 1, 1, 18'h021, 32'h0, 0, 32'hFFFFFF80, 0};
        tv[4]  = '{0, 1, 0, 18'h021, 32'h0, 1, 32'h00000080, 0};
        tv[5]  = '{0, 0, 0, 18'h013, 32'h0, 0, TRAP ? 32'h0 : 32'hDEADBEEF, TRAP};
        tv[6]  = '{0, 0, 1, 18'h020, 32'h0, 0, 32'h00008000, 0};
        tv[7]  = '{1, 1, 1, 18'h022, 32'hFFFFFF7F, 0, 32'h0, 0};
        tv[8]  = '{0, 1, 1, 18'h022, 32'h0, 0, 32'h0000007F, 0};
        tv[9]  = '{1, 0, 0, 18'h013, 32'h11223344, 2, 32'h0, TRAP};
        tv[10] = '{0, 0, 0, 18'h010, 32'h0, 0, TRAP ? 32'hDEADBEEF : 32'h11223344, 0};
        tv[11] = '{0, 1, 1, 18'h011, 32'h0, 0, TRAP ? 32'hFFFFFFBE : 32'h00000033, 0};

        reset = 1'b1;
        bus.req_valid = 0; bus.req_write = 0; bus.req_byte = 0; bus.req_signed = 0;
        bus.req_addr = 0; bus.req_wdata = 0; bus.resp_ready = 0;
        bus2.req_valid = 0; bus2.req_write = 0; bus2.req_byte = 0; bus2.req_signed = 0;
        bus2.req_addr = 0; bus2.req_wdata = 0; bus2.resp_ready = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_ready", bus.req_ready, 1);
        chk("reset_resp_valid", bus.resp_valid, 0);
        chk("reset_strobes", {bus.memRead, bus.memWrite}, 0);
        chk("reset_mem_addr", bus.mem_address, 0);
        chk("reset_mem_wdata", bus.mem_write_data, 0);
        chk("reset_byteop", bus.byteOperations, 0);
        chk("reset_rdata", bus.resp_rdata, 0);
        chk("reset_err", bus.resp_error, 0);

        // asynchronous reset while the write strobe is high
        bus.req_write = 1; bus.req_byte = 0; bus.req_addr = 18'h100; bus.req_wdata = 32'hA5A51234;
        bus.req_valid = 1;
        @(negedge clk);
        bus.req_valid = 0;
        k = 0;
        while (!bus.memWrite && k < 10) begin @(negedge clk); k++; end
        chk("rst_strobe_seen", bus.memWrite, 1);
        #2 reset = 1'b1;
        #1 chk("rst_memwrite_drop", bus.memWrite, 0);
        chk("rst_memread_low", bus.memRead, 0);
        ref_store(1, 0, 18'h100, 32'hA5A51234);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_after_ready", bus.req_ready, 1);
        chk("rst_after_resp_valid", bus.resp_valid, 0);
        chk("rst_after_strobe", bus.memWrite, 0);

        for (int i = 0; i < 12; i++) begin
            run_check($sformatf("tv%0d", i), tv[i].w, tv[i].b, tv[i].s, tv[i].a, tv[i].d,
                      tv[i].hold, tv[i].exp_rd, tv[i].exp_er);
            ref_store(tv[i].w, tv[i].b, tv[i].a, tv[i].d);
        end

        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom % 2); b = 1'($urandom % 2); s = 1'($urandom % 2);
            a = 18'($urandom_range(0, 255)); d = $urandom;
            r = ref_resp(w, b, s, a);
            run_check($sformatf("rnd%0d", i), w, b, s, a, d, $urandom_range(0, 2), r[31:0], r[32]);
            ref_store(w, b, a, d);
        end

        // stretched timing: two setup cycles, three strobe cycles
        @(negedge clk);
        bus2.req_write = 0; bus2.req_byte = 0; bus2.req_addr = 18'h040; bus2.req_valid = 1;
        @(negedge clk);
        bus2.req_valid = 0; bus2.req_addr = 18'h3FFFF;
        ma2 = bus2.mem_address;
        k = 1; first = 0; n = 0; moved = 0;
        while (!bus2.resp_valid && k < 60) begin
            if (bus2.memRead) begin
                n++;
                if (first == 0) first = k;
            end
            moved += int'(bus2.mem_address !== ma2) + int'(bus2.memWrite);
            @(negedge clk);
            k++;
        end
        chk("s2_strobe_start", first, 3);
        chk("s2_strobe_len", n, 3);
        chk("s2_addr_moved", moved, 0);
        chk("s2_mem_addr", ma2, 18'h040);
        chk("s2_lat", k, 7);
        chk("s2_rdata", bus2.resp_rdata, 32'hCAFE0123);
        bus2.resp_ready = 1;
        @(negedge clk);
        bus2.resp_ready = 0;
        chk("s2_done", {bus2.resp_valid, bus2.req_ready}, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
